// File: rtl/alu_sequencer.sv
// Command-driven sequencer for an external 8-bit combinational ALU.
// It owns a small register file and repeats ROL for a programmable number of iterations.
module alu_sequencer #(
    parameter int REG_SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_opc,
    input  logic [REG_SEL_W-1:0] cmd_dst,
    input  logic [REG_SEL_W-1:0] cmd_src_a,
    input  logic [REG_SEL_W-1:0] cmd_src_b,
    input  logic [2:0]           cmd_cnt,
    input  logic [7:0]           cmd_imm,
    output logic [1:0]           alu_insel,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    input  logic [7:0]           alu_out,
    input  logic                 alu_co,
    input  logic                 alu_z,
    input  logic [REG_SEL_W-1:0] rd_sel,
    output logic [7:0]           rd_data,
    output logic                 flag_c,
    output logic                 flag_z,
    output logic                 done
);

    localparam int NREGS = 1 << REG_SEL_W;

    localparam logic [2:0] OPC_AND = 3'b000;
    localparam logic [2:0] OPC_XOR = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_ROL = 3'b011;
    localparam logic [2:0] OPC_LDI = 3'b100;

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           opc_q, opc_d;
    logic [REG_SEL_W-1:0] dst_q, dst_d;
    logic [REG_SEL_W-1:0] a_sel_q, a_sel_d;
    logic [REG_SEL_W-1:0] src_b_q, src_b_d;
    logic [7:0]           imm_q, imm_d;
    logic [3:0]           iter_q, iter_d;
    logic                 flag_c_q, flag_c_d;
    logic                 flag_z_q, flag_z_d;
    logic                 done_q, done_d;
    logic [7:0]           regs_q [NREGS];
    logic [7:0]           regs_d [NREGS];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        opc_d    = opc_q;
        dst_d    = dst_q;
        a_sel_d  = a_sel_q;
        src_b_d  = src_b_q;
        imm_d    = imm_q;
        iter_d   = iter_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        done_d   = 1'b0;
        regs_d   = regs_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    opc_d   = cmd_opc;
                    dst_d   = cmd_dst;
                    a_sel_d = cmd_src_a;
                    src_b_d = cmd_src_b;
                    imm_d   = cmd_imm;
                    iter_d  = (cmd_cnt == 3'd0) ? 4'd8 : {1'b0, cmd_cnt};
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (opc_q)
                    OPC_AND, OPC_XOR, OPC_ADD: begin
                        regs_d[dst_q] = alu_out;
                        flag_c_d      = alu_co;
                        flag_z_d      = alu_z;
                        state_d       = IDLE;
                        done_d        = 1'b1;
                    end
                    OPC_ROL: begin
                        regs_d[dst_q] = alu_out;
                        flag_c_d      = alu_co;
                        flag_z_d      = alu_z;
                        iter_d        = iter_q - 4'd1;
                        // Later iterations rotate the destination in place.
                        a_sel_d       = dst_q;
                        if (iter_q == 4'd1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                    OPC_LDI: begin
                        regs_d[dst_q] = imm_q;
                        state_d       = IDLE;
                        done_d        = 1'b1;
                    end
                    default: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            opc_q    <= '0;
            dst_q    <= '0;
            a_sel_q  <= '0;
            src_b_q  <= '0;
            imm_q    <= '0;
            iter_q   <= '0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            done_q   <= 1'b0;
            // NOTE: the register file is cleared on reset, so it is built from resettable flops, not a RAM.
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            dst_q    <= dst_d;
            a_sel_q  <= a_sel_d;
            src_b_q  <= src_b_d;
            imm_q    <= imm_d;
            iter_q   <= iter_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
            done_q   <= done_d;
            regs_q   <= regs_d;
        end
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        alu_insel = 2'b00;
        alu_a     = 8'h00;
        alu_b     = 8'h00;
        if (state_q == EXEC) begin
            alu_insel = opc_q[1:0];
            alu_a     = regs_q[a_sel_q];
            alu_b     = regs_q[src_b_q];
        end
    end

    assign rd_data = regs_q[rd_sel];
    assign flag_c  = flag_c_q;
    assign flag_z  = flag_z_q;
    assign done    = done_q;

endmodule
